// File: rtl/audio_pkg.sv
// Shared types and frame geometry for the I2S output stage.
package audio_pkg;

    typedef enum logic [1:0] {
        HALTED = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2
    } state_t;

    localparam int FRAME_BITS = 64;
    localparam int SLOT_BITS  = 32;

    typedef logic signed [31:0] sample_t;

endpackage

// File: rtl/audio_i2s_out_sample_fifo.sv
// Sample FIFO between the synthesizer core and the I2S serializer.
// Writes are visible from the next cycle; there is no read bypass when empty.
module sample_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             overflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign overflow = push && full;
    assign rdata    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/audio_i2s_out.sv
// I2S DAC output stage: sample FIFO, BCLK/LRCK generation and a serializer
// that sends each mono sample on both channels, MSB first, one BCLK after LRCK.
module audio_i2s_out
    import audio_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int PRIME_LEVEL = 8,
    parameter int BCLK_HALF   = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     RUN,
    input  logic                     LD_FIFO,
    input  logic [31:0]              TONE,
    input  logic                     CLR_FLAGS,
    output logic                     FIFO_FULL,
    output logic [$clog2(DEPTH):0]   FIFO_LEVEL,
    output logic                     AUD_BCLK,
    output logic                     AUD_DACLRCK,
    output logic                     AUD_DACDAT,
    output logic                     UNDERRUN,
    output logic                     OVERFLOW,
    output state_t                   dbg_state
);

    localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int BW = $clog2(FRAME_BITS);
    localparam int LW = $clog2(DEPTH) + 1;

    state_t          state;
    logic [DW-1:0]   div_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [BW-1:0]   next_bit;
    sample_t         sample;
    logic [31:0]     shift;
    logic [31:0]     fifo_rdata;
    logic            fifo_empty;
    logic            fifo_ovf;
    logic            fall;
    logic            wrap;
    logic            pop;

    assign dbg_state = state;
    assign next_bit  = bit_cnt + 1'b1;
    assign fall      = (state == STREAM) && (div_cnt == DW'(BCLK_HALF - 1)) && AUD_BCLK;
    assign wrap      = fall && (next_bit == '0);
    // A frame ending with RUN low halts instead of popping.
    assign pop       = wrap && RUN;

    sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RESET),
        .push     (LD_FIFO),
        .pop      (pop),
        .wdata    (TONE),
        .rdata    (fifo_rdata),
        .full     (FIFO_FULL),
        .empty    (fifo_empty),
        .count    (FIFO_LEVEL),
        .overflow (fifo_ovf)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= HALTED;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            sample      <= '0;
            shift       <= '0;
            AUD_BCLK    <= 1'b0;
            AUD_DACLRCK <= 1'b0;
            AUD_DACDAT  <= 1'b0;
            UNDERRUN    <= 1'b0;
            OVERFLOW    <= 1'b0;
        end else begin
            if (fifo_ovf)                OVERFLOW <= 1'b1;
            else if (CLR_FLAGS)          OVERFLOW <= 1'b0;
            if (pop && fifo_empty)       UNDERRUN <= 1'b1;
            else if (CLR_FLAGS)          UNDERRUN <= 1'b0;

            case (state)
                HALTED: begin
                    if (RUN) state <= PRIME;
                end
                PRIME: begin
                    if (!RUN) begin
                        state <= HALTED;
                    end else if (FIFO_LEVEL >= LW'(PRIME_LEVEL)) begin
                        // bit_cnt parks at the last position so the first fall pops.
                        state       <= STREAM;
                        div_cnt     <= '0;
                        bit_cnt     <= BW'(FRAME_BITS - 1);
                        sample      <= '0;
                        shift       <= '0;
                        AUD_BCLK    <= 1'b0;
                        AUD_DACLRCK <= 1'b0;
                        AUD_DACDAT  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (div_cnt == DW'(BCLK_HALF - 1)) begin
                        div_cnt  <= '0;
                        AUD_BCLK <= !AUD_BCLK;
                        if (AUD_BCLK) begin
                            if (wrap && !RUN) begin
                                state       <= HALTED;
                                bit_cnt     <= '0;
                                AUD_BCLK    <= 1'b0;
                                AUD_DACLRCK <= 1'b0;
                                AUD_DACDAT  <= 1'b0;
                            end else begin
                                bit_cnt     <= next_bit;
                                AUD_DACLRCK <= next_bit[BW-1];
                                // Slot MSB goes out on the first BCLK after the LRCK change.
                                if (next_bit == BW'(1) || next_bit == BW'(SLOT_BITS + 1)) begin
                                    AUD_DACDAT <= sample[31];
                                    shift      <= {sample[30:0], 1'b0};
                                end else begin
                                    AUD_DACDAT <= shift[31];
                                    shift      <= {shift[30:0], 1'b0};
                                end
                                if (wrap) sample <= fifo_empty ? '0 : sample_t'(fifo_rdata);
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= HALTED;
            endcase
        end
    end

endmodule
